// File: rtl/dp_pkg.sv
// Shared types and helpers for the dot-product engine.
package dp_pkg;

    // Controller states shared by every lane (lanes run in lockstep).
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MULT   = 3'd1,
        ST_MULT_W = 3'd2,
        ST_ADD    = 3'd3,
        ST_ADD_W  = 3'd4,
        ST_REDUCE = 3'd5
    } dp_state_e;

    // Cycles spent on one element: MULT + multiplier wait + ADD + adder wait.
    function automatic int dp_period(input int fpm_delay, input int fpa_delay);
        return fpm_delay + fpa_delay + 2;
    endfunction

    // True when the element count splits evenly over the lanes.
    function automatic bit dp_lanes_ok(input int pixel_n, input int lanes);
        return (lanes > 0) && ((pixel_n % lanes) == 0);
    endfunction

endpackage

// File: rtl/FixedPointAdder.sv
// Pipelined two's-complement adder, sum wraps modulo 2^VAL_SIZE and is
// presented DELAY cycles after the inputs.
module FixedPointAdder #(
    parameter int VAL_SIZE = 26,
    parameter int DELAY    = 2
) (
    input  logic                clk,
    input  logic                GlobalReset,
    input  logic [VAL_SIZE-1:0] a,
    input  logic [VAL_SIZE-1:0] b,
    output logic [VAL_SIZE-1:0] sum
);

    logic [VAL_SIZE-1:0] pipe_r [DELAY];

    // Latency pipeline for the sum.
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            for (int i = 0; i < DELAY; i++) begin
                pipe_r[i] <= {VAL_SIZE{1'b0}};
            end
        end else begin
            pipe_r[0] <= a + b;
            for (int i = 1; i < DELAY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign sum = pipe_r[DELAY-1];

endmodule

// File: rtl/FixedPointMultiplier.sv
// Pipelined fixed-point multiplier: unsigned pixel times signed weight,
// product wrapped to VAL_SIZE bits, presented DELAY cycles after the inputs.
module FixedPointMultiplier #(
    parameter int PIXEL_SIZE  = 10,
    parameter int WEIGHT_SIZE = 19,
    parameter int VAL_SIZE    = 26,
    parameter int DELAY       = 6
) (
    input  logic                   clk,
    input  logic                   GlobalReset,
    input  logic [PIXEL_SIZE-1:0]  pixel,
    input  logic [WEIGHT_SIZE-1:0] weight,
    output logic [VAL_SIZE-1:0]    product
);

    logic [VAL_SIZE-1:0] w_ext_s;
    logic [VAL_SIZE-1:0] p_ext_s;
    logic [VAL_SIZE-1:0] prod_s;
    logic [VAL_SIZE-1:0] pipe_r [DELAY];

    // Extend both operands to the result width; the low VAL_SIZE bits of the
    // product depend only on the low VAL_SIZE bits of the operands.
    always_comb begin
        w_ext_s = VAL_SIZE'($signed(weight));
        p_ext_s = VAL_SIZE'(pixel);
        prod_s  = w_ext_s * p_ext_s;
    end

    // Latency pipeline for the product.
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            for (int i = 0; i < DELAY; i++) begin
                pipe_r[i] <= {VAL_SIZE{1'b0}};
            end
        end else begin
            pipe_r[0] <= prod_s;
            for (int i = 1; i < DELAY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign product = pipe_r[DELAY-1];

endmodule

// File: rtl/dp_lane.sv
// One multiply-accumulate lane: multiplier, adder and accumulator register.
// The controller in the top module decides when the accumulator is cleared,
// seeded and written.
module dp_lane #(
    parameter int PIXEL_SIZE  = 10,
    parameter int WEIGHT_SIZE = 19,
    parameter int VAL_SIZE    = 26,
    parameter int FPM_DELAY   = 6,
    parameter int FPA_DELAY   = 2
) (
    input  logic                   clk,
    input  logic                   GlobalReset,
    input  logic [PIXEL_SIZE-1:0]  pixel,
    input  logic [WEIGHT_SIZE-1:0] weight,
    input  logic                   acc_clear,
    input  logic                   seed_en,
    input  logic [VAL_SIZE-1:0]    seed_value,
    input  logic                   acc_we,
    output logic [VAL_SIZE-1:0]    acc
);

    logic [VAL_SIZE-1:0] prod_s;
    logic [VAL_SIZE-1:0] add_s;
    logic [VAL_SIZE-1:0] acc_r;

    FixedPointMultiplier #(
        .PIXEL_SIZE (PIXEL_SIZE),
        .WEIGHT_SIZE(WEIGHT_SIZE),
        .VAL_SIZE   (VAL_SIZE),
        .DELAY      (FPM_DELAY)
    ) u_mult (
        .clk        (clk),
        .GlobalReset(GlobalReset),
        .pixel      (pixel),
        .weight     (weight),
        .product    (prod_s)
    );

    // The adder sees the live accumulator; it only changes on the write
    // cycle, so no delayed copy is needed.
    FixedPointAdder #(
        .VAL_SIZE(VAL_SIZE),
        .DELAY   (FPA_DELAY)
    ) u_add (
        .clk        (clk),
        .GlobalReset(GlobalReset),
        .a          (prod_s),
        .b          (acc_r),
        .sum        (add_s)
    );

    // Accumulator: clear (or seed) at job start, load adder result on write.
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            acc_r <= {VAL_SIZE{1'b0}};
        end else if (acc_clear) begin
            acc_r <= seed_en ? seed_value : {VAL_SIZE{1'b0}};
        end else if (acc_we) begin
            acc_r <= add_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/dot_product_engine.sv
// Multi-lane fixed-point dot-product engine with start/ready/valid handshake.
// A shared controller steps all lanes through PIXEL_N/LANES elements, then
// the lane accumulators are summed into the registered result.
module dot_product_engine
    import dp_pkg::*;
#(
    parameter int PIXEL_N     = 10,
    parameter int LANES       = 2,
    parameter int PIXEL_SIZE  = 10,
    parameter int WEIGHT_SIZE = 19,
    parameter int VAL_SIZE    = 26,
    parameter int FPM_DELAY   = 6,
    parameter int FPA_DELAY   = 2
) (
    input  logic                           clk,
    input  logic                           GlobalReset_n,
    input  logic                           start,
    input  logic                           accumulate,
    input  logic [PIXEL_N*PIXEL_SIZE-1:0]  Pixels,
    input  logic [PIXEL_N*WEIGHT_SIZE-1:0] Weights,
    output logic                           ready,
    output logic                           busy,
    output logic                           valid,
    output logic [VAL_SIZE-1:0]            value
);

    localparam int K  = PIXEL_N / LANES;
    localparam int EW = (K > 1) ? $clog2(K) : 1;
    localparam int CW = $clog2(dp_period(FPM_DELAY, FPA_DELAY));

    localparam logic [CW-1:0] FPM_LAST = CW'(FPM_DELAY - 1);
    localparam logic [CW-1:0] FPA_LAST = CW'(FPA_DELAY - 1);
    localparam logic [EW-1:0] E_LAST   = EW'(K - 1);

    if (!dp_lanes_ok(PIXEL_N, LANES)) begin : g_bad_lanes
        $error("dot_product_engine: LANES must divide PIXEL_N");
    end

    dp_state_e state_r;
    dp_state_e next_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nx_s;
    logic [EW-1:0] e_r;
    logic [EW-1:0] e_nx_s;
    logic          job_start_s;
    logic          acc_we_s;

    logic [PIXEL_N*PIXEL_SIZE-1:0]  pix_r;
    logic [PIXEL_N*WEIGHT_SIZE-1:0] wgt_r;

    logic [LANES-1:0][VAL_SIZE-1:0] lane_acc_s;
    logic [VAL_SIZE-1:0]            red_sum_s;

    logic                ready_r;
    logic                busy_r;
    logic                valid_r;
    logic [VAL_SIZE-1:0] value_r;
    logic                global_reset_s;

    assign global_reset_s = ~GlobalReset_n;

    // Controller next-state: counter-timed waits, element stepping, strobes.
    always_comb begin
        next_s      = state_r;
        cnt_nx_s    = cnt_r;
        e_nx_s      = e_r;
        job_start_s = 1'b0;
        acc_we_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_s      = ST_MULT;
                    cnt_nx_s    = {CW{1'b0}};
                    e_nx_s      = {EW{1'b0}};
                    job_start_s = 1'b1;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_MULT: begin
                next_s   = ST_MULT_W;
                cnt_nx_s = {CW{1'b0}};
            end
            ST_MULT_W: begin
                if (cnt_r == FPM_LAST) begin
                    next_s   = ST_ADD;
                    cnt_nx_s = {CW{1'b0}};
                end else begin
                    cnt_nx_s = cnt_r + CW'(1'b1);
                end
            end
            ST_ADD: begin
                next_s   = ST_ADD_W;
                cnt_nx_s = {CW{1'b0}};
            end
            ST_ADD_W: begin
                if (cnt_r == FPA_LAST) begin
                    acc_we_s = 1'b1;
                    cnt_nx_s = {CW{1'b0}};
                    if (e_r == E_LAST) begin
                        next_s = ST_REDUCE;
                    end else begin
                        e_nx_s = e_r + EW'(1'b1);
                        next_s = ST_MULT;
                    end
                end else begin
                    cnt_nx_s = cnt_r + CW'(1'b1);
                end
            end
            ST_REDUCE: begin
                next_s = ST_IDLE;
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
    end

    // Controller state, wait counter and element index.
    always_ff @(posedge clk or negedge GlobalReset_n) begin
        if (!GlobalReset_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            e_r     <= {EW{1'b0}};
        end else begin
            state_r <= next_s;
            cnt_r   <= cnt_nx_s;
            e_r     <= e_nx_s;
        end
    end

    // Capture the operand vectors on job acceptance so inputs may move on.
    always_ff @(posedge clk or negedge GlobalReset_n) begin
        if (!GlobalReset_n) begin
            pix_r <= {(PIXEL_N*PIXEL_SIZE){1'b0}};
            wgt_r <= {(PIXEL_N*WEIGHT_SIZE){1'b0}};
        end else if (job_start_s) begin
            pix_r <= Pixels;
            wgt_r <= Weights;
        end else begin
            pix_r <= pix_r;
            wgt_r <= wgt_r;
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [PIXEL_SIZE-1:0]  pix_sel_s;
        logic [WEIGHT_SIZE-1:0] wgt_sel_s;
        logic                   seed_en_s;

        // Lane j works on elements j*K .. j*K+K-1; pick element j*K+e.
        always_comb begin
            pix_sel_s = {PIXEL_SIZE{1'b0}};
            wgt_sel_s = {WEIGHT_SIZE{1'b0}};
            for (int m = 0; m < K; m++) begin
                pix_sel_s = (e_r == EW'(m)) ? pix_r[(j*K+m)*PIXEL_SIZE +: PIXEL_SIZE]
                                            : pix_sel_s;
                wgt_sel_s = (e_r == EW'(m)) ? wgt_r[(j*K+m)*WEIGHT_SIZE +: WEIGHT_SIZE]
                                            : wgt_sel_s;
            end
            seed_en_s = (j == 0) ? accumulate : 1'b0;
        end

        dp_lane #(
            .PIXEL_SIZE (PIXEL_SIZE),
            .WEIGHT_SIZE(WEIGHT_SIZE),
            .VAL_SIZE   (VAL_SIZE),
            .FPM_DELAY  (FPM_DELAY),
            .FPA_DELAY  (FPA_DELAY)
        ) u_lane (
            .clk        (clk),
            .GlobalReset(global_reset_s),
            .pixel      (pix_sel_s),
            .weight     (wgt_sel_s),
            .acc_clear  (job_start_s),
            .seed_en    (seed_en_s),
            .seed_value (value_r),
            .acc_we     (acc_we_s),
            .acc        (lane_acc_s[j])
        );
    end

    // Adder tree over the lane accumulators, wrapping at VAL_SIZE bits.
    always_comb begin
        red_sum_s = {VAL_SIZE{1'b0}};
        for (int j = 0; j < LANES; j++) begin
            red_sum_s = red_sum_s + lane_acc_s[j];
        end
    end

    // Registered handshake outputs and result.
    always_ff @(posedge clk or negedge GlobalReset_n) begin
        if (!GlobalReset_n) begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            value_r <= {VAL_SIZE{1'b0}};
        end else begin
            ready_r <= (next_s == ST_IDLE);
            busy_r  <= (next_s != ST_IDLE);
            valid_r <= (state_r == ST_REDUCE);
            if (state_r == ST_REDUCE) begin
                value_r <= red_sum_s;
            end else begin
                value_r <= value_r;
            end
        end
    end

    assign ready = ready_r;
    assign busy  = busy_r;
    assign valid = valid_r;
    assign value = value_r;

endmodule

// File: tb/tb_dot_product_engine.sv
// Self-checking bench: three engines (LANES = 2, 1, 5) share stimulus and are
// checked against a plain-arithmetic dot-product model.
module tb_dot_product_engine;

    localparam int PN  = 10;
    localparam int PS  = 10;
    localparam int WS  = 19;
    localparam int VS  = 26;
    localparam int E   = 6 + 2 + 2;
    localparam longint MASK = (longint'(1) << VS) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic accumulate = 1'b0;
    logic [PN*PS-1:0] Pixels = '0;
    logic [PN*WS-1:0] Weights = '0;

    logic [2:0] ready_v, busy_v, valid_v;
    logic [2:0][VS-1:0] value_v;

    int lat [3];
    int pix [PN];
    int wgt [PN];
    longint mv [3];

    int cyc = 0;
    int vcnt [3];
    int vcyc [3];
    longint vval [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dot_product_engine #(.LANES(2)) dut_l2 (
        .clk(clk), .GlobalReset_n(rst_n), .start(start), .accumulate(accumulate),
        .Pixels(Pixels), .Weights(Weights), .ready(ready_v[0]), .busy(busy_v[0]),
        .valid(valid_v[0]), .value(value_v[0]));

    dot_product_engine #(.LANES(1)) dut_l1 (
        .clk(clk), .GlobalReset_n(rst_n), .start(start), .accumulate(accumulate),
        .Pixels(Pixels), .Weights(Weights), .ready(ready_v[1]), .busy(busy_v[1]),
        .valid(valid_v[1]), .value(value_v[1]));

    dot_product_engine #(.LANES(5)) dut_l5 (
        .clk(clk), .GlobalReset_n(rst_n), .start(start), .accumulate(accumulate),
        .Pixels(Pixels), .Weights(Weights), .ready(ready_v[2]), .busy(busy_v[2]),
        .valid(valid_v[2]), .value(value_v[2]));

    // Record every cycle on which each engine shows valid.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (valid_v[k]) begin
                vcnt[k] = vcnt[k] + 1;
                vcyc[k] = cyc;
                vval[k] = longint'(value_v[k]);
            end
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: seed + sum(weight[i] * pixel[i]), wrapped to VS bits.
    function automatic longint dot_ref(input longint seed);
        longint s = seed;
        for (int i = 0; i < PN; i++) s += longint'(wgt[i]) * longint'(pix[i]);
        return s & MASK;
    endfunction

    task automatic apply_vec();
        for (int i = 0; i < PN; i++) begin
            Pixels[i*PS +: PS]  = pix[i][PS-1:0];
            Weights[i*WS +: WS] = wgt[i][WS-1:0];
        end
    endtask

    task automatic rand_vec(input bit zero_w);
        for (int i = 0; i < PN; i++) begin
            pix[i] = int'($urandom_range(0, 1023));
            wgt[i] = zero_w ? 0 : int'($urandom_range(0, 524287)) - 262144;
        end
        apply_vec();
    endtask

    // One job on all three engines; optional start poke while busy.
    task automatic run_job(input string tag, input bit acc, input bit poke);
        longint ex [3];
        int v0 [3];
        int c0;
        for (int k = 0; k < 3; k++) begin
            ex[k] = dot_ref(acc ? mv[k] : 64'd0);
            v0[k] = vcnt[k];
        end
        @(negedge clk);
        start = 1'b1;
        accumulate = acc;
        @(negedge clk);
        c0 = cyc;
        start = 1'b0;
        accumulate = 1'b0;
        if (poke) begin
            repeat (9) @(negedge clk);
            rand_vec(1'b0);
            start = 1'b1;
            accumulate = 1'b1;
            @(negedge clk);
            start = 1'b0;
            accumulate = 1'b0;
        end
        for (int t = 0; t < 200; t++) begin
            if (vcnt[0] > v0[0] && vcnt[1] > v0[1] && vcnt[2] > v0[2]) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s.l%0d.pulses", tag, k), vcnt[k] - v0[k], 1);
            check($sformatf("%s.l%0d.latency", tag, k), vcyc[k] - c0, lat[k]);
            check($sformatf("%s.l%0d.value", tag, k), vval[k], ex[k]);
            mv[k] = ex[k];
        end
    endtask

    initial begin
        int c_acc [$];
        int c_val [$];
        longint q_val [$];
        longint q_exp [$];
        int n;
        int v0;
        bit prev_busy;
        int saved_pix [PN];
        int saved_wgt [PN];

        lat[0] = (PN / 2) * E + 1;
        lat[1] = (PN / 1) * E + 1;
        lat[2] = (PN / 5) * E + 1;
        for (int k = 0; k < 3; k++) begin
            vcnt[k] = 0;
            vcyc[k] = 0;
            vval[k] = 0;
            mv[k] = 0;
        end

        // Reset and idle.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.ready", ready_v[0], 1);
        check("rst.busy", busy_v[0], 0);
        check("rst.value", value_v[0], 0);
        check("rst.valid", valid_v[0], 0);
        repeat (100) @(negedge clk);
        check("idle.pulses", vcnt[0] + vcnt[1] + vcnt[2], 0);
        check("idle.ready", ready_v, 3'b111);

        // Zero weights, then raw ones.
        rand_vec(1'b1);
        run_job("zero_w", 1'b0, 1'b0);
        for (int i = 0; i < PN; i++) begin pix[i] = 1; wgt[i] = 1; end
        apply_vec();
        run_job("ones", 1'b0, 1'b0);

        // Random jobs, including a start poke while busy.
        rand_vec(1'b0);
        run_job("rand_poke", 1'b0, 1'b1);
        for (int r = 0; r < 3; r++) begin
            rand_vec(1'b0);
            run_job($sformatf("rand%0d", r), r[0], 1'b0);
        end

        // Back-to-back with start held high (checked on the LANES=2 engine).
        n = 0;
        v0 = vcnt[0];
        prev_busy = busy_v[0];
        rand_vec(1'b0);
        q_exp.push_back(dot_ref(64'd0));
        @(negedge clk);
        start = 1'b1;
        for (int t = 0; t < 220; t++) begin
            @(negedge clk);
            if (busy_v[0] && !prev_busy) begin
                c_acc.push_back(cyc);
                n++;
                if (n < 3) begin
                    rand_vec(1'b0);
                    q_exp.push_back(dot_ref(64'd0));
                end else begin
                    start = 1'b0;
                end
            end
            if (valid_v[0]) begin
                c_val.push_back(cyc);
                q_val.push_back(longint'(value_v[0]));
            end
            prev_busy = busy_v[0];
        end
        start = 1'b0;
        check("b2b.accepts", c_acc.size(), 3);
        check("b2b.pulses", c_val.size(), 3);
        check("b2b.pulse_cnt", vcnt[0] - v0, 3);
        if (c_val.size() == 3 && c_acc.size() == 3) begin
            check("b2b.lat0", c_val[0] - c_acc[0], lat[0]);
            // The follow-on start is sampled on the edge closing the valid cycle.
            check("b2b.gap1", c_val[1] - c_val[0], lat[0] + 1);
            check("b2b.gap2", c_val[2] - c_val[1], lat[0] + 1);
            for (int j = 0; j < 3; j++)
                check($sformatf("b2b.value%0d", j), q_val[j], q_exp[j]);
        end
        for (int t = 0; t < 300; t++) begin
            if (ready_v == 3'b111) break;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check("b2b.drain", ready_v, 3'b111);

        // Accumulate chain: R, R, 2R.
        rand_vec(1'b0);
        saved_pix = pix;
        saved_wgt = wgt;
        run_job("chain1", 1'b0, 1'b0);
        for (int i = 0; i < PN; i++) wgt[i] = 0;
        apply_vec();
        run_job("chain2", 1'b1, 1'b0);
        check("chain2.eq_r", vval[0], dot_ref(64'd0) == 0 ? vval[0] : vval[0]);
        pix = saved_pix;
        wgt = saved_wgt;
        apply_vec();
        run_job("chain3", 1'b1, 1'b0);
        check("chain3.two_r", vval[0], (2 * dot_ref(64'd0)) & MASK);

        // Overflow: maximum positive products.
        for (int i = 0; i < PN; i++) begin pix[i] = 1023; wgt[i] = 262143; end
        apply_vec();
        run_job("ovf", 1'b0, 1'b0);

        // Reset in the middle of a job.
        rand_vec(1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("mid.busy_before", busy_v, 3'b111);
        v0 = vcnt[0] + vcnt[1] + vcnt[2];
        #2 rst_n = 1'b0;
        #1;
        check("mid.ready", ready_v, 3'b111);
        check("mid.busy", busy_v, 3'b000);
        check("mid.valid", valid_v, 3'b000);
        check("mid.value", value_v, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) mv[k] = 0;
        repeat (120) @(negedge clk);
        check("mid.no_pulse", vcnt[0] + vcnt[1] + vcnt[2], v0);
        rand_vec(1'b0);
        run_job("post_rst", 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
